// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the traffic light controller phase sequencer.
//   phase_e    : sequencer phases (green, orange, all-red clearance)
//   side_t     : 2-bit approach code, with named constants N/E/S/W = 0..3
//   CNT_W_DEF  : default phase counter width
//   next_side  : rotation helper (3 wraps to 0)
// -----------------------------------------------------------------------------
package tlc_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_ORANGE = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  typedef logic [1:0] side_t;

  localparam side_t SIDE_N = 2'd0;
  localparam side_t SIDE_E = 2'd1;
  localparam side_t SIDE_S = 2'd2;
  localparam side_t SIDE_W = 2'd3;

  localparam int CNT_W_DEF = 4;

  // The 2-bit add wraps 3 -> 0 naturally.
  function automatic side_t next_side(input side_t s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// phase_sequencer_if
// Signal bundle between the phase sequencer and the lamp output stage.
//   T        : traffic-present flag of the side currently on SIDE (stage -> seq)
//   HOLD     : maintenance freeze                                  (stage -> seq)
//   G, O, R  : one-hot phase strobes                               (seq -> stage)
//   SIDE     : active approach 0..3                                (seq -> stage)
//   SIDE_CHG : pulse in the first green cycle of a new side        (seq -> stage)
// Modports: master = sequencer side, slave = output stage side.
// -----------------------------------------------------------------------------
interface phase_sequencer_if;
  import tlc_pkg::*;

  logic  T;
  logic  HOLD;
  logic  G;
  logic  O;
  logic  R;
  side_t SIDE;
  logic  SIDE_CHG;

  modport master (
    input  T, HOLD,
    output G, O, R, SIDE, SIDE_CHG
  );

  modport slave (
    output T, HOLD,
    input  G, O, R, SIDE, SIDE_CHG
  );

endinterface

// File: rtl/phase_cnt.sv
// -----------------------------------------------------------------------------
// phase_cnt
// Phase length up-counter with clear, hold and terminal-match output.
//   clk, srst : clock, synchronous active-high reset (clears the count)
//   clear     : restart at 0 on the next edge (phase entry)
//   hold      : freeze the count; takes priority over clear
//   limit     : phase length in cycles, 1 .. 2^CNT_W (one extra bit wide)
//   cnt       : current count
//   term      : high in the last cycle of the phase (cnt == limit-1)
// -----------------------------------------------------------------------------
module phase_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W:0]   limit,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   LIM_ONE = (CNT_W + 1)'(1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (hold) begin
      cnt_reg <= cnt_reg;
    end else if (clear) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

  // limit is one bit wider so a full 2^CNT_W-cycle phase ends at the all-ones count.
  assign term = ({1'b0, cnt_reg} == (limit - LIM_ONE));
  assign cnt  = cnt_reg;

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Density-aware phase sequencer for the lamp output stage. Rotates the four
// approaches 0->1->2->3->0; each side gets green (short or long depending on
// its traffic flag T, sampled in green cycle 0), then orange, then an optional
// all-red clearance before the next side.
//
// Ports:
//   CLK  : clock, all state on the rising edge
//   RST  : synchronous active-high reset, overrides HOLD
//   bus  : phase_sequencer_if.master (T, HOLD in; G, O, R, SIDE, SIDE_CHG out)
//
// Build option: define ALLRED_EN to include the all-red clearance phase.
// Without it orange goes straight to the next side's green, R is tied to 0
// and ALLRED_TIME has no effect.
// -----------------------------------------------------------------------------
module phase_sequencer
  import tlc_pkg::*;
#(
  parameter int GREEN_LONG  = 8,
  parameter int GREEN_SHORT = 4,
  parameter int ORANGE_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic                CLK,
  input logic                RST,
  phase_sequencer_if.master  bus
);

  localparam int LIM_W = CNT_W + 1;

  localparam logic [1:0] ST_GREEN  = PH_GREEN;
  localparam logic [1:0] ST_ORANGE = PH_ORANGE;

  localparam logic [LIM_W-1:0] LIM_LONG   = LIM_W'(GREEN_LONG);
  localparam logic [LIM_W-1:0] LIM_SHORT  = LIM_W'(GREEN_SHORT);
  localparam logic [LIM_W-1:0] LIM_ORANGE = LIM_W'(ORANGE_TIME);

`ifdef ALLRED_EN
  localparam logic [1:0]       ST_ALLRED  = PH_ALLRED;
  localparam logic [LIM_W-1:0] LIM_ALLRED = LIM_W'(ALLRED_TIME);
`endif

  // Reject illegal parameter sets at elaboration.
  if (GREEN_SHORT < 1 || GREEN_SHORT > GREEN_LONG || GREEN_LONG > (1 << CNT_W)) begin : g_bad_green
    $error("phase_sequencer: green lengths out of range");
  end
  if (ORANGE_TIME < 1 || ORANGE_TIME > (1 << CNT_W)) begin : g_bad_orange
    $error("phase_sequencer: ORANGE_TIME out of range");
  end
  if (ALLRED_TIME < 1 || ALLRED_TIME > (1 << CNT_W)) begin : g_bad_allred
    $error("phase_sequencer: ALLRED_TIME out of range");
  end

  logic [1:0]       state_reg, state_next;
  side_t            side_reg, side_next;
  logic             t_lat_reg, t_lat_next;
  logic             g_reg, o_reg;
  logic             side_chg_reg, side_chg_next;
`ifdef ALLRED_EN
  logic             r_reg;
`endif

  logic [CNT_W-1:0] cnt;
  logic             term;
  logic [LIM_W-1:0] limit;
  logic             green_c0;
  logic             t_eff;

  phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk   (CLK),
    .srst  (RST),
    .clear (term),      // every terminal match is a phase change
    .hold  (bus.HOLD),
    .limit (limit),
    .cnt   (cnt),
    .term  (term)
  );

  // In green cycle 0 the latch has not caught T yet, so the limit uses T live.
  assign green_c0 = (state_reg == ST_GREEN) && (cnt == '0);
  assign t_eff    = green_c0 ? bus.T : t_lat_reg;

  always_comb begin
    limit         = t_eff ? LIM_LONG : LIM_SHORT;
    state_next    = state_reg;
    side_next     = side_reg;
    t_lat_next    = t_lat_reg;
    side_chg_next = 1'b0;

    if (green_c0) begin
      t_lat_next = bus.T;
    end

    case (state_reg)
      ST_ORANGE: limit = LIM_ORANGE;
`ifdef ALLRED_EN
      ST_ALLRED: limit = LIM_ALLRED;
`endif
      default:   limit = t_eff ? LIM_LONG : LIM_SHORT;
    endcase

    if (term) begin
      case (state_reg)
        ST_GREEN: state_next = ST_ORANGE;
`ifdef ALLRED_EN
        ST_ORANGE: state_next = ST_ALLRED;
        ST_ALLRED: begin
          state_next    = ST_GREEN;
          side_next     = next_side(side_reg);
          side_chg_next = 1'b1;
        end
`else
        ST_ORANGE: begin
          state_next    = ST_GREEN;
          side_next     = next_side(side_reg);
          side_chg_next = 1'b1;
        end
`endif
        default: state_next = ST_GREEN;  // unreachable encoding: recover to green
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_GREEN;
      side_reg     <= SIDE_N;
      t_lat_reg    <= 1'b0;
      g_reg        <= 1'b1;
      o_reg        <= 1'b0;
      side_chg_reg <= 1'b0;
`ifdef ALLRED_EN
      r_reg        <= 1'b0;
`endif
    end else if (bus.HOLD) begin
      // Everything frozen except the change pulse, which must not repeat.
      side_chg_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      side_reg     <= side_next;
      t_lat_reg    <= t_lat_next;
      g_reg        <= (state_next == ST_GREEN);
      o_reg        <= (state_next == ST_ORANGE);
      side_chg_reg <= side_chg_next;
`ifdef ALLRED_EN
      r_reg        <= (state_next == ST_ALLRED);
`endif
    end
  end

  assign bus.G        = g_reg;
  assign bus.O        = o_reg;
  assign bus.SIDE     = side_reg;
  assign bus.SIDE_CHG = side_chg_reg;
`ifdef ALLRED_EN
  assign bus.R        = r_reg;
`else
  assign bus.R        = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
// Self-checking bench for phase_sequencer with default parameters. Adapts its
// expectations to whether ALLRED_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;
  import tlc_pkg::*;

`ifdef ALLRED_EN
  localparam bit ALLRED = 1'b1;
`else
  localparam bit ALLRED = 1'b0;
`endif
  localparam int G_LONG   = 8;
  localparam int G_SHORT  = 4;
  localparam int ORANGE_T = 2;
  localparam int ALLRED_T = 1;
  localparam int ROT      = 4 * (G_SHORT + ORANGE_T + (ALLRED ? ALLRED_T : 0));

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  phase_sequencer_if bus ();

  phase_sequencer #(
    .GREEN_LONG  (G_LONG),
    .GREEN_SHORT (G_SHORT),
    .ORANGE_TIME (ORANGE_T),
    .ALLRED_TIME (ALLRED_T),
    .CNT_W       (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase (0 green, 1 orange, 2 all-red), cycles elapsed in
  // the phase, side, latched density flag, change pulse.
  int m_ph, m_age, m_side;
  bit m_tlat, m_chg;

  function automatic int phase_len(input int ph, input bit t);
    if (ph == 0) return t ? G_LONG : G_SHORT;
    if (ph == 1) return ORANGE_T;
    return ALLRED_T;
  endfunction

  task automatic model_edge(input bit t, input bit h, input bit r);
    if (r) begin
      m_ph = 0; m_age = 0; m_side = 0; m_tlat = 1'b0; m_chg = 1'b0;
    end else if (h) begin
      m_chg = 1'b0;
    end else begin
      m_chg = 1'b0;
      if (m_ph == 0 && m_age == 0) m_tlat = t;
      m_age++;
      if (m_age == phase_len(m_ph, m_tlat)) begin
        m_age = 0;
        if (m_ph == 0) m_ph = 1;
        else if (m_ph == 1 && ALLRED) m_ph = 2;
        else begin
          m_ph   = 0;
          m_side = (m_side + 1) % 4;
          m_chg  = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [1:0] s;
    s = m_side[1:0];
    return {m_ph == 0, m_ph == 1, m_ph == 2, s, m_chg};
  endfunction

  function automatic logic [5:0] dut_out();
    return {bus.G, bus.O, bus.R, bus.SIDE, bus.SIDE_CHG};
  endfunction

  task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {G,O,R,SIDE,CHG} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare against the model.
  task automatic step(input bit t, input bit h, input bit r);
    bus.T = t; bus.HOLD = h; RST = r;
    @(posedge CLK);
    model_edge(t, h, r);
    @(negedge CLK);
    check_vec("model", dut_out(), model_out());
  endtask

  typedef struct {
    bit         t;
    bit         hold;
    bit         rst;
    logic [5:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit t, input bit h, input bit r, input bit g, input bit o,
                              input bit rr, input logic [1:0] side, input bit chg);
    vec_t v;
    v.t = t; v.hold = h; v.rst = r; v.exp = {g, o, rr, side, chg};
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int n, cnt, gcnt[4];
    bit reached, chg_seen;

    bus.T = 1'b0; bus.HOLD = 1'b0; RST = 1'b1;

    // ---- Table: reset, first side with T=0, a held green cycle 0 ----
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 0));
    if (ALLRED) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2'd0, 0));
    else        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd1, 1));
    if (ALLRED) vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd1, 1));
    else        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2'd1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 2'd1, 0));

    foreach (vecs[i]) begin
      step(vecs[i].t, vecs[i].hold, vecs[i].rst);
      check_vec($sformatf("table[%0d]", i), dut_out(), vecs[i].exp);
    end

    // ---- Full rotation with T=0: cycles from reset to side 0 again ----
    step(0, 0, 1);
    n = 0; cnt = 0; reached = 1'b0;
    for (int k = 0; k < 200 && !reached; k++) begin
      step(0, 0, 0);
      n++;
      if (bus.SIDE_CHG) cnt++;
      if (bus.SIDE_CHG && bus.SIDE == 2'd0) reached = 1'b1;
    end
    check_int("rotation_reached", int'(reached), 1);
    check_int("rotation_cycles", n, ROT);
    check_int("rotation_pulses", cnt, 4);

    // ---- T=1 only on side 2: long green there, short elsewhere ----
    step(0, 0, 1);
    for (int s = 0; s < 4; s++) gcnt[s] = 0;
    if (bus.G) gcnt[bus.SIDE]++;
    for (int k = 0; k < ROT + (G_LONG - G_SHORT) - 1; k++) begin
      step(m_side == 2, 1'b0, 1'b0);
      if (bus.G) gcnt[bus.SIDE]++;
    end
    check_int("green_side0", gcnt[0], G_SHORT);
    check_int("green_side1", gcnt[1], G_SHORT);
    check_int("green_side2", gcnt[2], G_LONG);
    check_int("green_side3", gcnt[3], G_SHORT);

    // ---- T rises in green cycle 2 of side 1: latched 0 keeps it short ----
    step(0, 0, 1);
    reached = 1'b0;
    for (int k = 0; k < 50 && !reached; k++) begin
      step(0, 0, 0);
      if (m_side == 1 && m_chg) reached = 1'b1;
    end
    check_int("side1_reached", int'(reached), 1);
    cnt = bus.G ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      step(k >= 2, 1'b0, 1'b0);
      if (!(bus.G && bus.SIDE == 2'd1)) break;
      cnt++;
    end
    check_int("late_t_green", cnt, G_SHORT);

    // ---- HOLD for 5 cycles in orange cycle 1: orange stretched to 7 ----
    step(0, 0, 1);
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      step(0, 0, 0);
      if (m_ph == 1) reached = 1'b1;
    end
    check_int("orange_reached", int'(reached), 1);
    cnt = bus.O ? 1 : 0;
    chg_seen = 1'b0;
    step(0, 0, 0);
    if (bus.O) cnt++;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0);
      if (bus.O) cnt++;
      if (bus.SIDE_CHG) chg_seen = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0);
      if (!bus.O) break;
      cnt++;
    end
    check_int("hold_orange_len", cnt, ORANGE_T + 5);
    check_int("hold_no_chg", int'(chg_seen), 0);

    // ---- RST together with HOLD in orange of side 3 ----
    step(0, 0, 1);
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      step(0, 0, 0);
      if (m_side == 3 && m_ph == 1) reached = 1'b1;
    end
    check_int("side3_orange_reached", int'(reached), 1);
    step(0, 1, 1);
    check_vec("rst_over_hold", dut_out(), {1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
    step(1, 0, 0);
    check_vec("after_rst", dut_out(), {1'b1, 1'b0, 1'b0, 2'd0, 1'b0});

    // ---- Randomized traffic, holds and resets against the model ----
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
